// File: rtl/pcie_dma_stats.sv
// Per-second DMA traffic statistics: counts TX/RX TLPs and payload DWORDs
// over a fixed window of TICKS_PER_SEC clocks and latches saturated totals
// for the BAR0 register block.
module pcie_dma_stats #(
  parameter int          TCQ           = 1,
  parameter int unsigned TICKS_PER_SEC = 32'd250000000
) (
  input  logic        clk,
  input  logic        sys_rst,
  input  logic        soft_reset,
  input  logic        tx_pkt,
  input  logic [2:0]  tx_dw_cnt,
  input  logic        rx_pkt,
  input  logic [2:0]  rx_dw_cnt,
  output logic [31:0] dma_tx_pps,
  output logic [31:0] dma_tx_dw,
  output logic [31:0] dma_rx_pps,
  output logic [31:0] dma_rx_dw,
  output logic        stats_update
);

  localparam int unsigned CW = 32;
  localparam logic [CW-1:0] TICK_LAST = CW'(TICKS_PER_SEC - 32'd1);

  // A one-cycle window cannot separate accumulate from latch; TCQ is a
  // simulation-only delay and must not be negative.
  if (TICKS_PER_SEC < 2 || TCQ < 0) begin : g_param_check
    $error("pcie_dma_stats: TICKS_PER_SEC must be in 2..2^32-1 and TCQ >= 0");
  end

  // Unsigned add that clamps at all-ones instead of wrapping.
  function automatic logic [CW-1:0] sat_add(input logic [CW-1:0] a,
                                            input logic [CW-1:0] b);
    logic [CW:0] s;
    s = {1'b0, a} + {1'b0, b};
    return s[CW] ? {CW{1'b1}} : s[CW-1:0];
  endfunction

  logic [CW-1:0] tick_q, tick_d;
  logic [CW-1:0] tx_pkt_acc_q, tx_pkt_acc_d, tx_dw_acc_q, tx_dw_acc_d;
  logic [CW-1:0] rx_pkt_acc_q, rx_pkt_acc_d, rx_dw_acc_q, rx_dw_acc_d;
  logic [CW-1:0] tx_pps_q, tx_pps_d, tx_dw_q, tx_dw_d;
  logic [CW-1:0] rx_pps_q, rx_pps_d, rx_dw_q, rx_dw_d;
  logic          update_q, update_d;

  logic [CW-1:0] tx_pkt_sum, tx_dw_sum, rx_pkt_sum, rx_dw_sum;
  logic          terminal;

  // Next-state: accumulate, close the window on the terminal tick, or restart on soft reset.
  always_comb begin
    tx_pkt_sum = sat_add(tx_pkt_acc_q, CW'(tx_pkt));
    tx_dw_sum  = sat_add(tx_dw_acc_q,  CW'(tx_dw_cnt));
    rx_pkt_sum = sat_add(rx_pkt_acc_q, CW'(rx_pkt));
    rx_dw_sum  = sat_add(rx_dw_acc_q,  CW'(rx_dw_cnt));
    terminal   = (tick_q == TICK_LAST);

    tick_d       = tick_q + CW'(1);
    tx_pkt_acc_d = tx_pkt_sum;
    tx_dw_acc_d  = tx_dw_sum;
    rx_pkt_acc_d = rx_pkt_sum;
    rx_dw_acc_d  = rx_dw_sum;
    tx_pps_d     = tx_pps_q;
    tx_dw_d      = tx_dw_q;
    rx_pps_d     = rx_pps_q;
    rx_dw_d      = rx_dw_q;
    update_d     = 1'b0;

    if (soft_reset) begin
      tick_d       = '0;
      tx_pkt_acc_d = '0;
      tx_dw_acc_d  = '0;
      rx_pkt_acc_d = '0;
      rx_dw_acc_d  = '0;
    end else if (terminal) begin
      // Terminal-cycle events belong to the closing window.
      tick_d       = '0;
      tx_pps_d     = tx_pkt_sum;
      tx_dw_d      = tx_dw_sum;
      rx_pps_d     = rx_pkt_sum;
      rx_dw_d      = rx_dw_sum;
      tx_pkt_acc_d = '0;
      tx_dw_acc_d  = '0;
      rx_pkt_acc_d = '0;
      rx_dw_acc_d  = '0;
      update_d     = 1'b1;
    end
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (sys_rst) begin
      tick_q       <= '0;
      tx_pkt_acc_q <= '0;
      tx_dw_acc_q  <= '0;
      rx_pkt_acc_q <= '0;
      rx_dw_acc_q  <= '0;
      tx_pps_q     <= '0;
      tx_dw_q      <= '0;
      rx_pps_q     <= '0;
      rx_dw_q      <= '0;
      update_q     <= 1'b0;
    end else begin
      tick_q       <= tick_d;
      tx_pkt_acc_q <= tx_pkt_acc_d;
      tx_dw_acc_q  <= tx_dw_acc_d;
      rx_pkt_acc_q <= rx_pkt_acc_d;
      rx_dw_acc_q  <= rx_dw_acc_d;
      tx_pps_q     <= tx_pps_d;
      tx_dw_q      <= tx_dw_d;
      rx_pps_q     <= rx_pps_d;
      rx_dw_q      <= rx_dw_d;
      update_q     <= update_d;
    end
  end

  assign dma_tx_pps   = tx_pps_q;
  assign dma_tx_dw    = tx_dw_q;
  assign dma_rx_pps   = rx_pps_q;
  assign dma_rx_dw    = rx_dw_q;
  assign stats_update = update_q;

endmodule

// File: tb/tb_pcie_dma_stats.sv
// Scoreboard bench for pcie_dma_stats: the driver keeps per-window event
// totals and pushes the expected report; the monitor pops on stats_update.
module tb_pcie_dma_stats;

  localparam int unsigned T = 16;

  if (T < 2) begin : g_ticks_chk
    $error("TICKS_PER_SEC below 2 is illegal");
  end

  typedef struct packed {
    logic [31:0] tx_pps;
    logic [31:0] tx_dw;
    logic [31:0] rx_pps;
    logic [31:0] rx_dw;
  } stats_t;

  logic        clk = 1'b0;
  logic        sys_rst = 1'b1;
  logic        soft_reset = 1'b0;
  logic        tx_pkt = 1'b0;
  logic [2:0]  tx_dw_cnt = 3'd0;
  logic        rx_pkt = 1'b0;
  logic [2:0]  rx_dw_cnt = 3'd0;
  logic [31:0] dma_tx_pps, dma_tx_dw, dma_rx_pps, dma_rx_dw;
  logic        stats_update;

  pcie_dma_stats #(.TCQ(1), .TICKS_PER_SEC(T)) dut (
    .clk          (clk),
    .sys_rst      (sys_rst),
    .soft_reset   (soft_reset),
    .tx_pkt       (tx_pkt),
    .tx_dw_cnt    (tx_dw_cnt),
    .rx_pkt       (rx_pkt),
    .rx_dw_cnt    (rx_dw_cnt),
    .dma_tx_pps   (dma_tx_pps),
    .dma_tx_dw    (dma_tx_dw),
    .dma_rx_pps   (dma_rx_pps),
    .dma_rx_dw    (dma_rx_dw),
    .stats_update (stats_update)
  );

  always #5 clk = ~clk;

  int unsigned checks = 0;
  int unsigned errors = 0;
  int unsigned cyc = 0;
  logic        rst_q = 1'b0;

  always @(posedge clk) begin
    cyc   <= cyc + 1;
    rst_q <= sys_rst;
  end

  // Reference model: plain per-window totals, clipped only when reported.
  longint unsigned m_tx_pkt, m_tx_dw, m_rx_pkt, m_rx_dw;
  int unsigned     m_pos;
  stats_t          exp_q[$];
  int unsigned     cyc_q[$];
  stats_t          last_exp = '0;

  function automatic logic [31:0] clip(input longint unsigned v);
    return (v > 64'hFFFF_FFFF) ? 32'hFFFF_FFFF : v[31:0];
  endfunction

  function automatic void model_clear();
    m_tx_pkt = 0; m_tx_dw = 0; m_rx_pkt = 0; m_rx_dw = 0; m_pos = 0;
  endfunction

  task automatic check32(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s at cycle %0d: got %h, expected %h", name, cyc, got, want);
    end
  endtask

  // One clock of stimulus; frc preloads the TX DWORD accumulator near its ceiling.
  task automatic step(input logic tp, input logic [2:0] td, input logic rp,
                      input logic [2:0] rd, input logic sr, input bit frc);
    @(negedge clk);
    sys_rst    = 1'b0;
    tx_pkt     = tp;
    tx_dw_cnt  = td;
    rx_pkt     = rp;
    rx_dw_cnt  = rd;
    soft_reset = sr;
    if (frc) begin
      force dut.tx_dw_acc_q = 32'hFFFF_FFFC;
      release dut.tx_dw_acc_q;
    end
    if (sr) begin
      model_clear();
    end else begin
      if (frc) m_tx_dw = 64'hFFFF_FFFC;
      m_tx_pkt += longint'(tp);
      m_tx_dw  += longint'(td);
      m_rx_pkt += longint'(rp);
      m_rx_dw  += longint'(rd);
      if (m_pos == T - 1) begin
        exp_q.push_back('{clip(m_tx_pkt), clip(m_tx_dw), clip(m_rx_pkt), clip(m_rx_dw)});
        cyc_q.push_back(cyc + 1);
        model_clear();
      end else begin
        m_pos++;
      end
    end
  endtask

  task automatic idle(input int unsigned n);
    for (int unsigned i = 0; i < n; i++) step(1'b0, 3'd0, 1'b0, 3'd0, 1'b0, 1'b0);
  endtask

  task automatic rand_step(input int unsigned sr_odds);
    step(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)),
         1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)),
         1'(sr_odds != 0 && $urandom_range(0, sr_odds - 1) == 0), 1'b0);
  endtask

  // Idle until the model sits at the start of a window.
  task automatic align();
    while (m_pos != 0) idle(1);
  endtask

  task automatic do_reset(input int unsigned n, input logic tp, input logic [2:0] td);
    for (int unsigned i = 0; i < n; i++) begin
      @(negedge clk);
      sys_rst    = 1'b1;
      soft_reset = 1'b0;
      tx_pkt     = tp;
      tx_dw_cnt  = td;
      rx_pkt     = tp;
      rx_dw_cnt  = td;
    end
    model_clear();
  endtask

  // Monitor: zeros under reset, pop-and-compare on update, hold otherwise.
  always @(negedge clk) begin
    stats_t      got;
    stats_t      e;
    int unsigned c;
    got = {dma_tx_pps, dma_tx_dw, dma_rx_pps, dma_rx_dw};
    if (rst_q) begin
      check32("reset_tx_pps", got.tx_pps, 32'd0);
      check32("reset_tx_dw", got.tx_dw, 32'd0);
      check32("reset_rx_pps", got.rx_pps, 32'd0);
      check32("reset_rx_dw", got.rx_dw, 32'd0);
      check32("reset_update", 32'(stats_update), 32'd0);
      exp_q.delete();
      cyc_q.delete();
      last_exp = '0;
    end else if (stats_update) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_update at cycle %0d: got pulse, expected none", cyc);
      end else begin
        e = exp_q.pop_front();
        c = cyc_q.pop_front();
        check32("update_cycle", cyc, c);
        check32("tx_pps", got.tx_pps, e.tx_pps);
        check32("tx_dw", got.tx_dw, e.tx_dw);
        check32("rx_pps", got.rx_pps, e.rx_pps);
        check32("rx_dw", got.rx_dw, e.rx_dw);
        last_exp = e;
      end
    end else begin
      checks++;
      if (got !== last_exp) begin
        errors++;
        $display("FAIL hold at cycle %0d: got %h, expected %h", cyc, got, last_exp);
      end
    end
  end

  initial begin
    model_clear();
    // Reset with traffic present: nothing may leak into the first window.
    do_reset(4, 1'b1, 3'd4);

    // Basic count: 5 TX x4 DW, 3 RX x2 DW, then a quiet window reporting zero.
    for (int unsigned i = 0; i < T; i++)
      step(1'(i < 5), (i < 5) ? 3'd4 : 3'd0, 1'(i >= 5 && i < 8), (i >= 5 && i < 8) ? 3'd2 : 3'd0,
           1'b0, 1'b0);
    idle(T);

    // Terminal-cycle event lands in the closing window only.
    for (int unsigned i = 0; i < T; i++)
      step(1'(i == T - 1), (i == T - 1) ? 3'd7 : 3'd0, 1'b0, 3'd0, 1'b0, 1'b0);
    idle(T);

    // Soft reset mid-window: discards ticks 0..12, restarts the window.
    for (int unsigned i = 0; i < 10; i++) step(1'b1, 3'd1, 1'b0, 3'd0, 1'b0, 1'b0);
    for (int unsigned i = 0; i < 3; i++) step(1'b1, 3'd5, 1'b1, 3'd5, 1'b1, 1'b0);
    for (int unsigned i = 0; i < T + 4; i++) rand_step(0);
    align();

    // Soft reset on the terminal tick suppresses the update.
    for (int unsigned i = 0; i < T; i++) step(1'b0, 3'd0, 1'(i == 2), 3'd3, 1'b0, 1'b0);
    for (int unsigned i = 0; i < T; i++) step(1'b1, 3'd6, 1'b1, 3'd1, 1'(i == T - 1), 1'b0);
    idle(T);

    // Saturation of the TX DWORD accumulator, then a fresh window.
    for (int unsigned i = 0; i < T; i++) step(1'b1, 3'd7, 1'b0, 3'd0, 1'b0, 1'(i == 3));
    for (int unsigned i = 0; i < T; i++) rand_step(0);

    // Random traffic with occasional soft resets, a mid-run reset, more traffic.
    for (int unsigned i = 0; i < 300; i++) rand_step(40);
    do_reset(2, 1'b1, 3'd7);
    for (int unsigned i = 0; i < 3 * T + 5; i++) rand_step(0);

    // Drain the last pending report.
    align();
    idle(2);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d pending reports, expected 0", exp_q.size());
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
